primitive_assembler: RTL and testbench

- Sits directly downstream of the instruction decode stage. Consumes its Vertex, StartPrimitive, PrimitiveType, EndPrimitive and Draw outputs, plus a vertex strobe decoded from SETVERTEX.
- Buffers the vertices of one primitive between STARTPRIMITIVE and ENDPRIMITIVE.
- On DRAW, emits the buffered vertices to the rasterizer as complete point, line or triangle groups over a valid/ready handshake.

---
 rtl/primitive_assembler_if.sv | 31 +++
 rtl/primitive_assembler.sv | 134 +++++++++++++
 tb/tb_primitive_assembler.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/primitive_assembler_if.sv
// Decode-side strobes in, rasterizer vertex stream out (valid/ready), plus status.
interface primitive_assembler_if #(
  parameter int CNT_W = 5
);
  logic             VertexValid;
  logic [31:0]      Vertex;
  logic             StartPrimitive;
  logic [3:0]       PrimitiveType;
  logic             EndPrimitive;
  logic             Draw;
  logic             OutValid;
  logic             OutReady;
  logic [31:0]      OutVertex;
  logic [3:0]       OutType;
  logic             OutFirst;
  logic             OutLast;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] VertexCount;
  logic             Error;

  modport master (
    output VertexValid, Vertex, StartPrimitive, PrimitiveType, EndPrimitive, Draw, OutReady,
    input  OutValid, OutVertex, OutType, OutFirst, OutLast, Busy, Done, VertexCount, Error
  );

  modport slave (
    input  VertexValid, Vertex, StartPrimitive, PrimitiveType, EndPrimitive, Draw, OutReady,
    output OutValid, OutVertex, OutType, OutFirst, OutLast, Busy, Done, VertexCount, Error
  );
endinterface

// File: rtl/primitive_assembler.sv
// Buffers one primitive's vertices and on Draw streams complete point/line/triangle groups.
// First beat one cycle after Draw, then one vertex per cycle; OutReady low holds the current beat.
module primitive_assembler #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                 CLK,
  input  logic                 RESET,
  primitive_assembler_if.slave io
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CLOSED, S_EMIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] rd_idx_q, rd_idx_d;
  logic [1:0]       phase_q, phase_d;
  logic [3:0]       type_q, type_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic [31:0]      vbuf [DEPTH];
  logic             wr_en;

  logic             type_ok;
  logic [1:0]       grp_size;
  logic [CNT_W-1:0] remaining;
  logic             emit_end;
  logic             out_vld;
  logic             last_in_grp;

  assign type_ok     = (io.PrimitiveType < 4'd3);
  assign grp_size    = (type_q == 4'd0) ? 2'd1 : (type_q == 4'd1) ? 2'd2 : 2'd3;
  assign remaining   = count_q - rd_idx_q;
  // Only a group boundary may end emission, so partial trailing groups never start.
  assign emit_end    = (phase_q == 2'd0) && (remaining < {{(CNT_W-2){1'b0}}, grp_size});
  assign out_vld     = (state_q == S_EMIT) && !emit_end;
  assign last_in_grp = (phase_q == grp_size - 2'd1);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_idx_d = rd_idx_q;
    phase_d  = phase_q;
    type_d   = type_q;
    done_d   = 1'b0;
    error_d  = error_q;
    wr_en    = 1'b0;

    if (state_q != S_EMIT && io.StartPrimitive) begin
      // A restart mid-collect is a protocol slip; replacing a closed primitive is not.
      if (state_q == S_COLLECT || !type_ok) error_d = 1'b1;
      count_d = '0;
      if (type_ok) begin
        type_d  = io.PrimitiveType;
        state_d = S_COLLECT;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (io.VertexValid || io.EndPrimitive || io.Draw) error_d = 1'b1;
        end
        S_COLLECT: begin
          if (io.VertexValid) begin
            if (count_q == CNT_W'(DEPTH)) begin
              error_d = 1'b1;
            end else begin
              wr_en   = 1'b1;
              count_d = count_q + 1'b1;
            end
          end
          if (io.EndPrimitive) state_d = S_CLOSED;
          if (io.Draw) error_d = 1'b1;
        end
        S_CLOSED: begin
          if (io.Draw) begin
            rd_idx_d = '0;
            phase_d  = 2'd0;
            state_d  = S_EMIT;
          end
          if (io.VertexValid || io.EndPrimitive) error_d = 1'b1;
        end
        S_EMIT: begin
          if (emit_end) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            count_d = '0;
          end else if (io.OutReady) begin
            rd_idx_d = rd_idx_q + 1'b1;
            phase_d  = last_in_grp ? 2'd0 : phase_q + 2'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      rd_idx_q <= '0;
      phase_q  <= 2'd0;
      type_q   <= 4'd0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_idx_q <= rd_idx_d;
      phase_q  <= phase_d;
      type_q   <= type_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) vbuf[count_q[IDX_W-1:0]] <= io.Vertex;
  end

  assign io.OutValid    = out_vld;
  assign io.OutVertex   = out_vld ? vbuf[rd_idx_q[IDX_W-1:0]] : 32'd0;
  assign io.OutFirst    = out_vld && (phase_q == 2'd0);
  assign io.OutLast     = out_vld && last_in_grp;
  assign io.OutType     = type_q;
  assign io.Busy        = (state_q == S_EMIT);
  assign io.Done        = done_q;
  assign io.VertexCount = count_q;
  assign io.Error       = error_q;
endmodule

// File: tb/tb_primitive_assembler.sv
// Directed bench: drivers push expected beats into a queue, a negedge monitor pops and compares.
module tb_primitive_assembler;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  typedef struct packed {
    logic [31:0] v;
    logic [3:0]  t;
    logic        f;
    logic        l;
  } beat_t;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  primitive_assembler_if #(.CNT_W(CNT_W)) io();
  primitive_assembler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.CLK(CLK), .RESET(RESET), .io(io));

  int          vectors = 0;
  int          miscompares = 0;
  int          xfer_cnt = 0;
  beat_t       exp_q[$];
  logic [31:0] model_v[$];
  logic [3:0]  model_t = 4'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  logic  stall_pend = 1'b0;
  logic  prev_done = 1'b0;
  beat_t stall_beat;
  always @(negedge CLK) begin
    beat_t cur;
    beat_t e;
    cur.v = io.OutVertex; cur.t = io.OutType; cur.f = io.OutFirst; cur.l = io.OutLast;
    if (RESET) begin
      stall_pend = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (stall_pend)
        check("stall_hold", 64'({io.OutValid, cur}), 64'({1'b1, stall_beat}));
      if (io.OutValid && io.OutReady) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(cur), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'(cur), 64'(e));
        end
      end
      if (!io.OutValid)
        check("idle_outs_zero", 64'({io.OutVertex, io.OutFirst, io.OutLast}), 64'(0));
      if (prev_done && io.Done) check("done_one_cycle", 64'(1), 64'(0));
      prev_done  = io.Done;
      stall_pend = io.OutValid && !io.OutReady;
      stall_beat = cur;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    io.StartPrimitive = 1'b0;
    io.VertexValid    = 1'b0;
    io.EndPrimitive   = 1'b0;
    io.Draw           = 1'b0;
  endtask

  task automatic send_start(input logic [3:0] t);
    io.StartPrimitive = 1'b1;
    io.PrimitiveType  = t;
    tick();
    if (t < 4'd3) begin
      model_v.delete();
      model_t = t;
    end
  endtask

  task automatic send_vtx(input logic [31:0] v);
    io.VertexValid = 1'b1;
    io.Vertex      = v;
    tick();
    if (model_v.size() < DEPTH) model_v.push_back(v);
  endtask

  task automatic send_end();
    io.EndPrimitive = 1'b1;
    tick();
  endtask

  task automatic send_draw(input bit expect_emit);
    int g;
    int n;
    beat_t b;
    if (expect_emit) begin
      g = int'(model_t) + 1;
      n = (model_v.size() / g) * g;
      for (int i = 0; i < n; i++) begin
        b.v = model_v[i]; b.t = model_t; b.f = (i % g) == 0; b.l = (i % g) == g - 1;
        exp_q.push_back(b);
      end
    end
    io.Draw = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int budget, output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (io.Done) begin
        got = 1'b1;
        cyc = i + 1;
        break;
      end
    end
    if (!got) check("done_timeout", 64'(0), 64'(1));
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    exp_q.delete();
    RESET = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    int x0;
    logic [0:4] rdy_pat;
    io.VertexValid = 0; io.Vertex = 0; io.StartPrimitive = 0; io.PrimitiveType = 0;
    io.EndPrimitive = 0; io.Draw = 0; io.OutReady = 1'b1;
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_outvalid", 64'(io.OutValid), 64'(0));
    check("rst_busy", 64'(io.Busy), 64'(0));
    check("rst_done", 64'(io.Done), 64'(0));
    check("rst_error", 64'(io.Error), 64'(0));
    check("rst_outtype", 64'(io.OutType), 64'(0));
    check("rst_count", 64'(io.VertexCount), 64'(0));
    RESET = 1'b0;
    tick();

    // Triangle, three vertices
    send_start(4'd2);
    send_vtx(32'h0001_0002); send_vtx(32'h0003_0004); send_vtx(32'h0005_0006);
    send_end();
    send_draw(1);
    @(negedge CLK);
    check("tri_busy", 64'(io.Busy), 64'(1));
    check("tri_valid_after_draw", 64'(io.OutValid), 64'(1));
    wait_done(20, c);
    check("tri_done_latency", 64'(c), 64'(4));
    check("tri_error", 64'(io.Error), 64'(0));
    check("tri_drained", 64'(exp_q.size()), 64'(0));

    // Lines, five vertices: last one dropped
    send_start(4'd1);
    for (int i = 1; i <= 5; i++) send_vtx(32'h0100_0000 + 32'(i));
    send_end();
    check("lines_count_before", 64'(io.VertexCount), 64'(5));
    send_draw(1);
    wait_done(20, c);
    check("lines_count_after", 64'(io.VertexCount), 64'(0));
    check("lines_drained", 64'(exp_q.size()), 64'(0));

    // Points with backpressure 0,1,0,0,1
    send_start(4'd0);
    send_vtx(32'hAAAA_0001); send_vtx(32'hAAAA_0002);
    send_end();
    x0 = xfer_cnt;
    io.OutReady = 1'b0;
    send_draw(1);
    rdy_pat = 5'b01001;
    for (int i = 0; i < 5; i++) begin
      io.OutReady = rdy_pat[i];
      tick();
    end
    io.OutReady = 1'b1;
    wait_done(10, c);
    check("bp_transfers", 64'(xfer_cnt - x0), 64'(2));
    check("bp_done_latency", 64'(c), 64'(2));
    check("bp_error", 64'(io.Error), 64'(0));
    check("bp_drained", 64'(exp_q.size()), 64'(0));

    // Overflow: DEPTH+2 vertices
    send_start(4'd0);
    for (int i = 0; i < DEPTH + 2; i++) send_vtx(32'h0001_0001 * 32'(i + 1));
    check("ovf_count", 64'(io.VertexCount), 64'(DEPTH));
    check("ovf_error", 64'(io.Error), 64'(1));
    send_end();
    send_draw(1);
    wait_done(40, c);
    check("ovf_drained", 64'(exp_q.size()), 64'(0));

    // Protocol errors from IDLE, restart mid-collect
    do_reset();
    check("proto_error_clear", 64'(io.Error), 64'(0));
    send_draw(0);
    check("proto_draw_idle_err", 64'(io.Error), 64'(1));
    send_start(4'd7);
    check("proto_bad_type_busy", 64'(io.Busy), 64'(0));
    check("proto_bad_type_count", 64'(io.VertexCount), 64'(0));
    send_end();
    send_draw(0);
    repeat (3) tick();
    check("proto_still_idle", 64'(io.Busy), 64'(0));
    send_start(4'd1);
    send_vtx(32'hBBBB_0001); send_vtx(32'hBBBB_0002);
    send_start(4'd2);
    check("proto_restart_count", 64'(io.VertexCount), 64'(0));
    send_vtx(32'hCCCC_0001); send_vtx(32'hCCCC_0002); send_vtx(32'hCCCC_0003);
    send_end();
    send_draw(1);
    wait_done(20, c);
    check("proto_drained", 64'(exp_q.size()), 64'(0));

    // Reset mid-emit after one of three beats
    send_start(4'd2);
    send_vtx(32'h0D0D_0001); send_vtx(32'h0D0D_0002); send_vtx(32'h0D0D_0003);
    send_end();
    x0 = xfer_cnt;
    send_draw(1);
    @(negedge CLK);
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    check("rst_emit_outvalid", 64'(io.OutValid), 64'(0));
    check("rst_emit_busy", 64'(io.Busy), 64'(0));
    check("rst_emit_one_beat", 64'(xfer_cnt - x0), 64'(1));
    exp_q.delete();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("rst_emit_no_done", 64'(io.Done), 64'(0));
    end
    @(posedge CLK);
    #1;
    check("rst_emit_error", 64'(io.Error), 64'(0));
    send_start(4'd2);
    send_vtx(32'h0E0E_0001); send_vtx(32'h0E0E_0002); send_vtx(32'h0E0E_0003);
    send_end();
    send_draw(1);
    wait_done(20, c);
    check("post_rst_drained", 64'(exp_q.size()), 64'(0));
    check("post_rst_error", 64'(io.Error), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
